// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: FSM state encoding,
// operation-select constants and the op_sel-to-slice inversion mapping.
package alu_serial_seq_pkg;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operation select; bit0 inverts A in the slice (s0), bit1 inverts B (s1)
    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB_B    = 2'b10;  // A - B with cin_init = 1
    localparam logic [1:0] OP_SUB_A    = 2'b01;  // B - A with cin_init = 1
    localparam logic [1:0] OP_INV_BOTH = 2'b11;

    // Returns {s1, s0} for the slice given a latched operation select.
    function automatic logic [1:0] op_to_slice_sel(input logic [1:0] op);
        logic [1:0] sel;
        case (op)
            OP_ADD:      sel = 2'b00;
            OP_SUB_B:    sel = 2'b10;
            OP_SUB_A:    sel = 2'b01;
            OP_INV_BOTH: sel = 2'b11;
            default:     sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer. Feeds one operand bit pair per cycle (LSB first)
// to an external 1-bit ALU slice, chains the slice carry between bits and
// assembles the returned bits into a WIDTH-bit result with carry and zero.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op_sel,
    input  logic             cin_init,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_c,
    output logic             slice_s0,
    output logic             slice_s1,
    input  logic             slice_out,
    input  logic             slice_carry
);

    localparam int              IDX_W    = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_sh;        // latched A, shifted right so bit[idx] sits at bit 0
    logic [WIDTH-1:0] b_sh;        // latched B, shifted the same way
    logic [WIDTH-1:0] stage;       // result bits collected during RUN, shifted in from the MSB
    logic [1:0]       sel_q;
    logic             cin_q;
    logic             carry_q;     // slice carry of the previous bit
    logic [WIDTH-1:0] next_result;

    assign ready       = (state != ST_RUN);
    assign done        = (state == ST_DONE);
    assign next_result = {slice_out, stage[WIDTH-1:1]};

    // Drive the slice only while a bit is being processed; hold it at 0 otherwise.
    always_comb begin
        // NOTE: every output gets a default before the branch so no latch is inferred.
        slice_a  = 1'b0;
        slice_b  = 1'b0;
        slice_c  = 1'b0;
        slice_s0 = 1'b0;
        slice_s1 = 1'b0;
        if (state == ST_RUN) begin
            slice_a              = a_sh[0];
            slice_b              = b_sh[0];
            slice_c              = (idx == '0) ? cin_q : carry_q;
            {slice_s1, slice_s0} = op_to_slice_sel(sel_q);
        end
    end

    // Sequencer: accept requests when idle/done, step one bit per cycle in RUN,
    // and publish result/carry/zero only on the transition into DONE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the working registers are reset too, so partial work from an
            // interrupted operation can never leak into a later one.
            state     <= ST_IDLE;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            stage     <= '0;
            sel_q     <= 2'b00;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    stage   <= next_result;
                    carry_q <= slice_carry;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        state     <= ST_DONE;
                        result    <= next_result;
                        carry_out <= slice_carry;
                        zero      <= (next_result == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request (no bubble after DONE)
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        sel_q <= op_sel;
                        cin_q <= cin_init;
                        idx   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
